bmaccum: RTL and testbench

- Backward-pass counterpart of the forward multiply-accumulate stage.
- Takes NC child-side error terms (deltas) plus the NP×NC weight matrix, and produces NP parent-side propagated sums: out[p] = Σ_c (delta[c] * w[c][p]) >>> (WD-1).
- Serialised: NP parallel multipliers, one child column per cycle.
- Sits between the B-side error producer and the A-side (previous layer) error consumer, using the same valid/ready handshake as the forward path.

---
 rtl/bmaccum_if.sv | 21 ++
 rtl/bmaccum.sv | 129 ++++++++++++
 tb/tb_bmaccum.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bmaccum_if.sv
// Valid/ready/data handshake bundle shared by the
// backward MAC and its neighbours.
interface bmaccum_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/bmaccum.sv
// Backward multiply-accumulate: propagates NC child deltas
// through the weight matrix into NP parent sums, one column/cycle.
module bmaccum #(
    parameter  int NP = 4,
    parameter  int NC = 4,
    parameter  int WD = 4,
    localparam int WO = $clog2(NC) + 1 + WD,
    localparam int DW = NC*WD + NP*NC*WD,
    localparam int CW = (NC > 1) ? $clog2(NC) : 1
) (
    input  logic      iCLK,
    input  logic      iRST,
    bmaccum_if.slave  s_bs,
    bmaccum_if.master m_as
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_load;
    logic                  w_acc;
    logic                  w_ready;
    logic                  w_valid;
    logic                  w_last;

    logic [CW-1:0]         r_cnt;
    logic [DW-1:0]         r_opd;
    logic signed [WO-1:0]  r_acc  [NP];
    logic signed [WO-1:0]  w_term [NP];
    logic signed [WD-1:0]  w_d;

    assign w_last = (r_cnt == CW'(NC - 1));

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_acc   = 1'b0;
        w_ready = 1'b0;
        w_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (s_bs.valid) begin
                    w_load = 1'b1;
                    w_next = ACC;
                end
            end
            ACC: begin
                w_acc = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_valid = 1'b1;
                if (m_as.ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Ready is masked by reset so nothing is offered while held in reset
    assign s_bs.ready = w_ready & iRST;
    assign m_as.valid = w_valid;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_acc && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_opd <= '0;
        end else if (w_load) begin
            r_opd <= s_bs.data;
        end
    end

    assign w_d = r_opd[int'(r_cnt)*WD +: WD];

    for (genvar p = 0; p < NP; p++) begin : g_lane
        logic signed [WD-1:0]   w_w;
        logic signed [2*WD-1:0] w_prod;
        logic signed [2*WD-1:0] w_shf;
        logic signed [WD:0]     w_sh;

        assign w_w    = r_opd[NC*WD + (int'(r_cnt)*NP + p)*WD +: WD];
        assign w_prod = w_d * w_w;
        // Floor shift back to Q1.(WD-1); result always fits WD+1 bits
        assign w_shf  = w_prod >>> (WD - 1);
        assign w_sh   = w_shf[WD:0];
        assign w_term[p] = WO'(w_sh);

        always_ff @(posedge iCLK or negedge iRST) begin
            if (!iRST) begin
                r_acc[p] <= '0;
            end else if (w_load) begin
                r_acc[p] <= '0;
            end else if (w_acc) begin
                r_acc[p] <= r_acc[p] + w_term[p];
            end
        end

        assign m_as.data[p*WO +: WO] = r_acc[p];
    end

endmodule

// File: tb/tb_bmaccum.sv
// Randomised self-checking bench for bmaccum against an
// arithmetic reference of the propagated error sums.
module tb_bmaccum;
    localparam int NP = 4;
    localparam int NC = 4;
    localparam int WD = 4;
    localparam int WO = $clog2(NC) + 1 + WD;
    localparam int DW = NC*WD + NP*NC*WD;
    localparam int OW = NP*WO;

    logic clk;
    logic rst_n;

    bmaccum_if #(.W(DW)) bs ();
    bmaccum_if #(.W(OW)) as_i ();

    bmaccum #(.NP(NP), .NC(NC), .WD(WD)) u_dut (
        .iCLK (clk),
        .iRST (rst_n),
        .s_bs (bs),
        .m_as (as_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int dd [NC];
    int ww [NC][NP];
    int ex [NP];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fdiv8(input int v);
        int r;
        r = ((v % 8) + 8) % 8;
        return (v - r) / 8;
    endfunction

    function automatic logic [DW-1:0] pack_in();
        logic [DW-1:0] v;
        logic [31:0]   t;
        v = '0;
        for (int c = 0; c < NC; c++) begin
            t = dd[c];
            v[c*WD +: WD] = t[WD-1:0];
            for (int p = 0; p < NP; p++) begin
                t = ww[c][p];
                v[NC*WD + (c*NP+p)*WD +: WD] = t[WD-1:0];
            end
        end
        return v;
    endfunction

    function automatic logic [OW-1:0] model();
        logic [OW-1:0] v;
        logic [31:0]   t;
        v = '0;
        for (int p = 0; p < NP; p++) begin
            ex[p] = 0;
            for (int c = 0; c < NC; c++)
                ex[p] += fdiv8(dd[c] * ww[c][p]);
            t = ex[p];
            v[p*WO +: WO] = t[WO-1:0];
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] junk();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic fill(input int dv, input int wv);
        for (int c = 0; c < NC; c++) begin
            dd[c] = dv;
            for (int p = 0; p < NP; p++) ww[c][p] = wv;
        end
    endtask

    task automatic fill_rand();
        for (int c = 0; c < NC; c++) begin
            dd[c] = int'($urandom_range(0, 15)) - 8;
            for (int p = 0; p < NP; p++)
                ww[c][p] = int'($urandom_range(0, 15)) - 8;
        end
    endtask

    task automatic chk_lanes(input string tag);
        logic signed [WO-1:0] lane;
        for (int p = 0; p < NP; p++) begin
            lane = as_i.data[p*WO +: WO];
            chk(tag, longint'(lane), longint'(ex[p]));
        end
    endtask

    // Offer a transaction and wait for the accepting edge.
    task automatic accept(input logic [DW-1:0] din);
        int n;
        @(negedge clk);
        bs.valid = 1'b1;
        bs.data  = din;
        n = 0;
        while (!bs.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", longint'(n < 40), 1);
        @(posedge clk);
        #1;
        bs.valid = 1'b0;
        bs.data  = junk();
    endtask

    task automatic wait_valid(input string tag);
        int lat;
        lat = 0;
        while (!as_i.valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, NC);
    endtask

    task automatic run_txn(input string tag, input int stall);
        logic [OW-1:0] e;
        e = model();
        accept(pack_in());
        wait_valid(tag);
        chk_lanes(tag);
        @(negedge clk);
        for (int i = 0; i < stall; i++) begin
            bs.valid = 1'b1;
            bs.data  = junk();
            @(negedge clk);
            chk({tag, "_hold_v"}, longint'(as_i.valid), 1);
            chk({tag, "_hold_r"}, longint'(bs.ready), 0);
            chk({tag, "_hold_d"}, longint'(as_i.data), longint'(e));
        end
        bs.valid   = 1'b0;
        as_i.ready = 1'b1;
        @(posedge clk);
        #1;
        as_i.ready = 1'b0;
        chk({tag, "_idle_v"}, longint'(as_i.valid), 0);
        chk({tag, "_idle_r"}, longint'(bs.ready), 1);
    endtask

    initial begin
        logic [OW-1:0] e1;
        rst_n      = 1'b0;
        bs.valid   = 1'b0;
        bs.data    = '0;
        as_i.ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", longint'(bs.ready), 0);
        chk("rst_valid", longint'(as_i.valid), 0);
        chk("rst_data", longint'(as_i.data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", longint'(bs.ready), 1);

        fill(4, 4);
        run_txn("half", 0);

        fill(-8, -8);
        dd[0] = -8; dd[1] = 7; dd[2] = 0; dd[3] = 1;
        run_txn("signs", 1);

        fill(-8, -8);
        run_txn("maxneg", 0);

        fill(0, 0);
        dd[0] = 1;
        for (int p = 0; p < NP; p++) ww[0][p] = -1;
        run_txn("floor", 0);

        fill_rand();
        run_txn("bp", 10);

        // Abort in the middle of accumulation
        fill(7, 7);
        accept(pack_in());
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(as_i.valid), 0);
        chk("mid_rst_data", longint'(as_i.data), 0);
        chk("mid_rst_ready", longint'(bs.ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_rel", longint'(bs.ready), 1);
        fill(0, 0);
        dd[2] = 3;
        for (int p = 0; p < NP; p++) ww[2][p] = p - 2;
        run_txn("fresh", 0);

        // Back-to-back with valid held high
        fill_rand();
        e1 = model();
        @(negedge clk);
        as_i.ready = 1'b1;
        bs.valid   = 1'b1;
        bs.data    = pack_in();
        @(posedge clk);
        #1;
        chk("b2b_acc1", longint'(bs.ready), 0);
        wait_valid("b2b1");
        chk("b2b1_data", longint'(as_i.data), longint'(e1));
        fill_rand();
        e1 = model();
        bs.data = pack_in();
        @(posedge clk);
        #1;
        chk("b2b_hs_v", longint'(as_i.valid), 0);
        chk("b2b_hs_r", longint'(bs.ready), 1);
        @(posedge clk);
        #1;
        chk("b2b_acc2", longint'(bs.ready), 0);
        bs.valid = 1'b0;
        bs.data  = junk();
        wait_valid("b2b2");
        chk("b2b2_data", longint'(as_i.data), longint'(e1));
        @(posedge clk);
        #1;
        as_i.ready = 1'b0;

        for (int k = 0; k < 20; k++) begin
            fill_rand();
            run_txn("rand", int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
